// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg: shared widths, element/word types and unpacker FSM states.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package sort_pkg;

  localparam int ELEM_W = 2;
  localparam int N_ELEM = 4;

  typedef logic [ELEM_W-1:0]        elem_t;
  typedef logic [N_ELEM*ELEM_W-1:0] word_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/word_fifo.sv
// -----------------------------------------------------------------------------
// word_fifo: DEPTH-entry synchronous FIFO with registered full/empty/count.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import sort_pkg::*;

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [AW-1:0]    LAST_PTR = AW'(DEPTH-1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !r_full;
  assign w_do_pop  = pop && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_do_pop && !w_do_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/sorted_word_unpacker.sv
// -----------------------------------------------------------------------------
// sorted_word_unpacker: buffers sorted words, streams their elements one per cycle.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module sorted_word_unpacker #(
  parameter int ELEM_W    = sort_pkg::ELEM_W,
  parameter int N_ELEM    = sort_pkg::N_ELEM,
  parameter int DEPTH     = 2,
  parameter bit MIN_FIRST = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_ELEM*ELEM_W-1:0]  in_word,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [ELEM_W-1:0]         out_elem,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(N_ELEM)-1:0] out_idx,
  output logic                      out_last,
  output logic                      order_err
);
  import sort_pkg::*;

  localparam int WORD_W = N_ELEM * ELEM_W;
  localparam int IDX_W  = $clog2(N_ELEM);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM-1);
  localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W+1)'(DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_sel;
  logic             r_in_ready;
  logic             r_order_err;
  logic [WORD_W-1:0] w_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_cnt;
  logic [CNT_W:0]   w_cnt_nxt;
  logic             w_push;
  logic             w_xfer;
  logic             w_last;
  logic             w_pop;
  logic             w_unsorted;

  assign w_push    = in_valid && r_in_ready && !w_fifo_full;
  assign w_xfer    = out_valid && out_ready;
  assign w_last    = (r_idx == LAST_IDX);
  assign w_pop     = w_xfer && w_last;
  assign w_cnt_nxt = ({1'b0, w_fifo_cnt} + (CNT_W+1)'(w_push)) - (CNT_W+1)'(w_pop);

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (in_word),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Emission position maps to a word element, reversed when smallest goes first.
  assign w_sel = MIN_FIRST ? (LAST_IDX - r_idx) : r_idx;

  always_comb begin
    w_state_nxt = r_state;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_elem    = '0;
    case (r_state)
      IDLE: begin
        if (w_push) begin
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        out_valid = !w_fifo_empty;
        out_last  = w_last;
        for (int i = 0; i < N_ELEM; i++) begin
          if (w_sel == IDX_W'(i)) begin
            out_elem = w_head[i*ELEM_W +: ELEM_W];
          end
        end
        if (w_pop && (w_cnt_nxt == '0)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_unsorted = 1'b0;
    for (int i = 0; i < N_ELEM-1; i++) begin
      if (in_word[i*ELEM_W +: ELEM_W] < in_word[(i+1)*ELEM_W +: ELEM_W]) begin
        w_unsorted = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_order_err <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      end
      r_in_ready <= (w_cnt_nxt < DEPTH_W);
      if (w_push && w_unsorted) begin
        r_order_err <= 1'b1;
      end
    end
  end

  assign out_idx   = r_idx;
  assign in_ready  = r_in_ready;
  assign order_err = r_order_err;

endmodule

`default_nettype wire

// File: tb/tb_sorted_word_unpacker.sv
// -----------------------------------------------------------------------------
// tb_sorted_word_unpacker: directed + random stream checks for both emission orders.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_sorted_word_unpacker;

  localparam int EW    = 2;
  localparam int NE    = 4;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_word = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       rdy0, rdy1, val0, val1, last0, last1, err0, err1;
  logic [1:0] elem0, elem1, idx0, idx1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: buffered words plus position inside the head word.
  logic [7:0] mq[$];
  int         m_pos   = 0;
  bit         m_ready = 0;
  bit         m_err   = 0;

  always #5 clk = ~clk;

  sorted_word_unpacker #(.ELEM_W(EW), .N_ELEM(NE), .DEPTH(DEPTH), .MIN_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(rdy0),
    .out_elem(elem0), .out_valid(val0), .out_ready(out_ready), .out_idx(idx0),
    .out_last(last0), .order_err(err0)
  );

  sorted_word_unpacker #(.ELEM_W(EW), .N_ELEM(NE), .DEPTH(DEPTH), .MIN_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(rdy1),
    .out_elem(elem1), .out_valid(val1), .out_ready(out_ready), .out_idx(idx1),
    .out_last(last1), .order_err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_sorted(input logic [7:0] w);
    for (int i = 0; i < NE-1; i++) begin
      if (w[i*EW +: EW] < w[(i+1)*EW +: EW]) return 0;
    end
    return 1;
  endfunction

  function automatic logic [7:0] rand_sorted();
    logic [7:0]  w;
    int unsigned e;
    e = $urandom_range(3, 0);
    w[1:0] = 2'(e);
    for (int i = 1; i < NE; i++) begin
      e = $urandom_range(e, 0);
      w[i*EW +: EW] = 2'(e);
    end
    return w;
  endfunction

  task automatic compare();
    logic [7:0] w;
    bit         v;
    v = (mq.size() > 0);
    chk("in_ready0", 32'(rdy0), 32'(m_ready));
    chk("in_ready1", 32'(rdy1), 32'(m_ready));
    chk("out_valid0", 32'(val0), 32'(v));
    chk("out_valid1", 32'(val1), 32'(v));
    chk("order_err0", 32'(err0), 32'(m_err));
    chk("order_err1", 32'(err1), 32'(m_err));
    if (v) begin
      w = mq[0];
      chk("out_elem0", 32'(elem0), 32'(w[m_pos*EW +: EW]));
      chk("out_elem1", 32'(elem1), 32'(w[(NE-1-m_pos)*EW +: EW]));
      chk("out_idx0", 32'(idx0), 32'(m_pos));
      chk("out_idx1", 32'(idx1), 32'(m_pos));
      chk("out_last0", 32'(last0), 32'(m_pos == NE-1));
      chk("out_last1", 32'(last1), 32'(m_pos == NE-1));
    end
  endtask

  // One clock: predict handshakes from pre-edge state, advance model, check outputs.
  task automatic cycle();
    bit         push, xfer;
    logic [7:0] w;
    push = in_valid && m_ready;
    xfer = (mq.size() > 0) && out_ready;
    w    = in_word;
    @(posedge clk);
    if (!rst) begin
      if (xfer) begin
        m_pos++;
        if (m_pos == NE) begin
          void'(mq.pop_front());
          m_pos = 0;
        end
      end
      if (push) begin
        mq.push_back(w);
        if (!is_sorted(w)) m_err = 1;
      end
      m_ready = (mq.size() < DEPTH);
    end
    #1;
    compare();
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    mq.delete();
    m_pos = 0; m_ready = 0; m_err = 0;
    #1;
    chk("rst_in_ready", 32'(rdy0 | rdy1), 32'(0));
    chk("rst_out_valid", 32'(val0 | val1), 32'(0));
    chk("rst_out_elem", 32'(elem0 | elem1), 32'(0));
    chk("rst_out_idx", 32'(idx0 | idx1), 32'(0));
    chk("rst_out_last", 32'(last0 | last1), 32'(0));
    chk("rst_order_err", 32'(err0 | err1), 32'(0));
  endtask

  initial begin
    // Power-on reset and release.
    #1;
    do_reset();
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    // Basic stream.
    in_word = 8'b00_01_10_11; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (5) cycle();

    // Back-pressure: third back-to-back word must be refused.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_word = rand_sorted(); in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b1;
    repeat (10) cycle();

    // Order violation: accepted, emitted unchanged, flag sticks.
    in_word = 8'b11_00_00_00; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (6) cycle();
    in_word = rand_sorted(); in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (5) cycle();

    // Reset after two of four elements.
    in_word = 8'b00_01_10_11; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle(); cycle();
    do_reset();
    cycle();
    rst = 1'b0;
    cycle();
    in_word = 8'b00_01_10_11; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (5) cycle();

    // Random traffic with occasional malformed words.
    do_reset();
    cycle();
    rst = 1'b0;
    cycle();
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom % 2) == 0;
      in_word   = (($urandom % 8) == 0) ? 8'($urandom) : rand_sorted();
      out_ready = ($urandom % 4) != 0;
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sorted_word_unpacker.md
# sorted_word_unpacker

Consumer end of the odd-even sorter pipeline: accepts packed, already-sorted 8-bit words (four 2-bit elements) and emits the elements one per cycle on a valid/ready stream. A small word buffer decouples the sorter's fixed-rate output from a back-pressured downstream. Each accepted word is also checked against the sorter's ordering convention, with a sticky error flag on any violation. Sits directly after the sorter's final pipeline register. The integrator supplies `in_valid` delayed to match the sorter latency.

## Interface
- `ELEM_W`, 2: width of one element in bits.
- `N_ELEM`, 4: elements per word; word width is `N_ELEM*ELEM_W`.
- `DEPTH`, 2: word buffer depth, ≥1.
- `MIN_FIRST`, 0: 0 emits element 0 (largest) first; 1 emits element `N_ELEM-1` (smallest) first.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_word` in `N_ELEM*ELEM_W`: sorted word; element i at bits `[i*ELEM_W +: ELEM_W]`.
- `in_valid` in 1: `in_word` valid this cycle.
- `in_ready` out 1: buffer can accept a word.
- `out_elem` out `ELEM_W`: current element.
- `out_valid` out 1: `out_elem` valid.
- `out_ready` in 1: downstream accepts `out_elem`.
- `out_idx` out `$clog2(N_ELEM)`: position in emission order, 0 = first emitted.
- `out_last` out 1: current element is the last of its word.
- `order_err` out 1: sticky ordering violation flag.

## Operation
- **Ordering convention.** This is the sorter's convention: element 0 is the maximum, and in a well-formed word element i ≥ element i+1 (unsigned) for every i.
- **Push.** A word is pushed on `in_valid && in_ready`. There is no bypass: the buffer is written, then read.
- **Two-state FSM.**
  - IDLE (buffer empty): `out_valid` = 0.
  - EMIT: the head word is presented one element at a time, starting at element 0 (`MIN_FIRST`=0) or element `N_ELEM-1` (`MIN_FIRST`=1).
- **Handshake.**
  - An element transfers on `out_valid && out_ready`; the index counter then advances.
  - On transfer of the `out_last` element, the head word pops and the counter wraps to 0.
  - If the buffer is still non-empty, the FSM stays in EMIT; otherwise it returns to IDLE.
- **Holding.** While `out_valid && !out_ready`, `out_elem`, `out_idx` and `out_last` hold stable.
- **Order check.**
  - Evaluated on each pushed word: any i with element i < element i+1 sets `order_err` on the next edge.
  - `order_err` stays set until `rst`.
  - A word that fails the check is still accepted and emitted unchanged.
- **Equal elements** are legal (no error).
- **`out_valid` never depends combinationally on `out_ready`.**

## Timing
- **Reset values:** `in_ready`=0 while `rst` is asserted; `out_valid`=0, `out_elem`=0, `out_idx`=0, `out_last`=0, `order_err`=0. Buffer is empty, FSM in IDLE.
- **After reset release:** `in_ready`=1 on the first edge after `rst` deasserts.
- **`in_ready`:** registered; equals "count < DEPTH".
- **Push into an empty buffer:** first element is valid on the cycle after the accepting edge (latency 1).
- **Throughput:** one element per cycle with `out_ready` held high, so a word takes `N_ELEM` cycles. There is no bubble between the last element of one word and the first element of the next.
- **Push and pop in the same cycle:** count is unchanged. When full, `in_ready`=0, so no simultaneous push occurs.
- **`rst` mid-word:** discards all buffered words and the partial emission immediately (asynchronous).

## Structure
- Package `sort_pkg` holds:
  - `ELEM_W` and `N_ELEM` default constants;
  - the element and word typedefs;
  - the FSM state enum (IDLE, EMIT).
- Sub-module `word_fifo`: a parameterised `DEPTH`-entry synchronous FIFO with registered full/empty and count, on `clk`/`rst`.
- The top level holds the FSM, the index counter, the element mux and the order checker.

## Test plan
- **Basic stream.** Reset, then push `in_word`=8'b00_01_10_11 (elements 3,2,1,0 at positions 0..3) with `out_ready`=1.
  - Required: `out_elem` 3,2,1,0 on four consecutive cycles.
  - `out_idx` 0..3, `out_last` only on the fourth, `order_err`=0.
- **Back-pressure and full buffer.** Push 3 words back-to-back while `out_ready`=0.
  - Required: `in_ready` drops after the 2nd push; the 3rd word is not accepted.
  - `out_elem`/`out_idx` are held.
  - Releasing `out_ready` drains 8 elements with no gap.
- **Order violation.** Push 8'b11_00_00_00, i.e. element 3 = 3 > element 0 = 0.
  - Required: `order_err`=1 from the next cycle and stays set.
  - Elements 0,0,0,3 are still emitted.
- **Reset mid-word.** Assert `rst` after 2 of 4 elements.
  - Required: `out_valid`=0 and `order_err`=0 immediately.
  - The buffer is empty; the next pushed word emits from `out_idx`=0.
- **Reverse order.** `MIN_FIRST`=1 with 8'b00_01_10_11.
  - Required: emission order 0,1,2,3.
  - `out_last` on element value 3.
